// File: rtl/sys_cmd_parser.sv
// sys_cmd_parser: collects command frames from the UART RX deserialiser and
// drives one-cycle register / ALU requests, then returns read data or ALU
// results to the TX side over a valid/ready handshake.
//   Frames : AA addr wdata (write), BB addr (read),
//            CC opa opb fun (ALU), DD fun (ALU reusing held operands)
// Ports:
//   CLK, RST                        clock, synchronous active-high reset
//   RX_P_DATA/RX_D_VLD              received word + strobe
//   PAR_ERR/FRM_ERR                 line errors qualifying the current word
//   WR_EN/RD_EN/ADDR/WR_DATA        register file request
//   RD_DATA/RD_DATA_VLD             register file response
//   ALU_EN/ALU_FUN/OP_A/OP_B        ALU request (operands held between commands)
//   ALU_OUT/ALU_OUT_VLD             ALU response (two words wide)
//   TX_P_DATA/TX_D_VLD/TX_READY     response word handshake
//   BUSY                            any state other than IDLE
//   ERR/ERR_CODE                    error pulse, code held until next error
//     1 bad opcode, 2 inter-word timeout, 3 RX line error,
//     4 word received while busy, 5 response timeout
module sys_cmd_parser #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int FUN_WIDTH      = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
   input  logic                    RX_D_VLD,
   input  logic                    PAR_ERR,
   input  logic                    FRM_ERR,
   output logic                    WR_EN,
   output logic                    RD_EN,
   output logic [ADDR_WIDTH-1:0]   ADDR,
   output logic [DATA_WIDTH-1:0]   WR_DATA,
   input  logic [DATA_WIDTH-1:0]   RD_DATA,
   input  logic                    RD_DATA_VLD,
   output logic                    ALU_EN,
   output logic [FUN_WIDTH-1:0]    ALU_FUN,
   output logic [DATA_WIDTH-1:0]   OP_A,
   output logic [DATA_WIDTH-1:0]   OP_B,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VLD,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD,
   input  logic                    TX_READY,
   output logic                    BUSY,
   output logic                    ERR,
   output logic [2:0]              ERR_CODE
);
   typedef enum logic [3:0] {
      IDLE, GET_ADDR, GET_WDATA, GET_OPA, GET_OPB, GET_FUN,
      ISSUE, WAIT_RSP, SEND_LO, SEND_HI
   } state_t;
   typedef enum logic [1:0] {CMD_WR, CMD_RD, CMD_ALU} cmd_t;

   // The timer counts idle cycles spent in a timed state; the timeout fires on
   // the edge that would complete the TIMEOUT_CYCLES-th idle cycle.
   localparam int            TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   state_t                  state, state_nxt;
   cmd_t                    cmd, cmd_nxt;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_nxt, opa_q, opa_nxt, opb_q, opb_nxt;
   logic [FUN_WIDTH-1:0]    fun_q, fun_nxt;
   logic [DATA_WIDTH-1:0]   tx_q, tx_nxt, hi_q, hi_nxt;
   logic                    err_q, err_nxt;
   logic [2:0]              code_q, code_nxt;
   logic [TW-1:0]           timer;
   logic                    accepting, timed, tmo;

   assign accepting = state inside {IDLE, GET_ADDR, GET_WDATA, GET_OPA, GET_OPB, GET_FUN};
   assign timed     = (TIMEOUT_CYCLES != 0) && (state inside {GET_ADDR, GET_WDATA, GET_OPA,
                                                               GET_OPB, GET_FUN, WAIT_RSP});
   assign tmo       = timed && (timer == TMO_LAST);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         cmd     <= CMD_WR;
         addr_q  <= '0;
         wdata_q <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         fun_q   <= '0;
         tx_q    <= '0;
         hi_q    <= '0;
         err_q   <= 1'b0;
         code_q  <= '0;
         timer   <= '0;
      end else begin
         state   <= state_nxt;
         cmd     <= cmd_nxt;
         addr_q  <= addr_nxt;
         wdata_q <= wdata_nxt;
         opa_q   <= opa_nxt;
         opb_q   <= opb_nxt;
         fun_q   <= fun_nxt;
         tx_q    <= tx_nxt;
         hi_q    <= hi_nxt;
         err_q   <= err_nxt;
         code_q  <= code_nxt;
         if ((accepting && RX_D_VLD) || (state_nxt != state) || !timed)
            timer <= '0;
         else
            timer <= timer + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      cmd_nxt   = cmd;
      addr_nxt  = addr_q;
      wdata_nxt = wdata_q;
      opa_nxt   = opa_q;
      opb_nxt   = opb_q;
      fun_nxt   = fun_q;
      tx_nxt    = tx_q;
      hi_nxt    = hi_q;
      err_nxt   = 1'b0;
      code_nxt  = code_q;
      if (accepting && RX_D_VLD) begin
         // a line error outranks a coincident timeout
         if (PAR_ERR || FRM_ERR) begin
            err_nxt   = 1'b1;
            code_nxt  = 3'd3;
            state_nxt = IDLE;
         end else begin
            case (state)
               IDLE: begin
                  case (RX_P_DATA[7:0])
                     8'hAA:   begin cmd_nxt = CMD_WR;  state_nxt = GET_ADDR; end
                     8'hBB:   begin cmd_nxt = CMD_RD;  state_nxt = GET_ADDR; end
                     8'hCC:   begin cmd_nxt = CMD_ALU; state_nxt = GET_OPA;  end
                     8'hDD:   begin cmd_nxt = CMD_ALU; state_nxt = GET_FUN;  end
                     default: begin err_nxt = 1'b1; code_nxt = 3'd1; end
                  endcase
               end
               GET_ADDR: begin
                  addr_nxt  = RX_P_DATA[ADDR_WIDTH-1:0];
                  state_nxt = (cmd == CMD_WR) ? GET_WDATA : ISSUE;
               end
               GET_WDATA: begin wdata_nxt = RX_P_DATA; state_nxt = ISSUE; end
               GET_OPA:   begin opa_nxt = RX_P_DATA; state_nxt = GET_OPB; end
               GET_OPB:   begin opb_nxt = RX_P_DATA; state_nxt = GET_FUN; end
               GET_FUN:   begin fun_nxt = RX_P_DATA[FUN_WIDTH-1:0]; state_nxt = ISSUE; end
               default: ;
            endcase
         end
      end else begin
         // here RX_D_VLD can only be set in a non-accepting state
         if (RX_D_VLD) begin
            err_nxt  = 1'b1;
            code_nxt = 3'd4;
         end
         case (state)
            GET_ADDR, GET_WDATA, GET_OPA, GET_OPB, GET_FUN: begin
               if (tmo) begin err_nxt = 1'b1; code_nxt = 3'd2; state_nxt = IDLE; end
            end
            ISSUE: state_nxt = (cmd == CMD_WR) ? IDLE : WAIT_RSP;
            WAIT_RSP: begin
               // a response arriving with the timeout wins
               if (cmd == CMD_RD && RD_DATA_VLD) begin
                  tx_nxt    = RD_DATA;
                  state_nxt = SEND_LO;
               end else if (cmd == CMD_ALU && ALU_OUT_VLD) begin
                  tx_nxt    = ALU_OUT[DATA_WIDTH-1:0];
                  hi_nxt    = ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
                  state_nxt = SEND_LO;
               end else if (tmo) begin
                  err_nxt   = 1'b1;
                  code_nxt  = 3'd5;
                  state_nxt = IDLE;
               end
            end
            SEND_LO: begin
               if (TX_READY) begin
                  if (cmd == CMD_ALU) begin
                     tx_nxt    = hi_q;
                     state_nxt = SEND_HI;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
            SEND_HI: if (TX_READY) state_nxt = IDLE;
            default: ;
         endcase
      end
   end

   assign WR_EN     = (state == ISSUE) && (cmd == CMD_WR);
   assign RD_EN     = (state == ISSUE) && (cmd == CMD_RD);
   assign ALU_EN    = (state == ISSUE) && (cmd == CMD_ALU);
   assign ADDR      = addr_q;
   assign WR_DATA   = wdata_q;
   assign OP_A      = opa_q;
   assign OP_B      = opb_q;
   assign ALU_FUN   = fun_q;
   assign TX_P_DATA = tx_q;
   assign TX_D_VLD  = state inside {SEND_LO, SEND_HI};
   assign BUSY      = (state != IDLE);
   assign ERR       = err_q;
   assign ERR_CODE  = code_q;
endmodule

// File: tb/tb_sys_cmd_parser.sv
// Testbench for sys_cmd_parser: table of command frames plus hand-written
// sequences for timeout, back-pressure, overlap and reset corners. Expected
// register/ALU requests, TX words and error codes are queued when stimulus is
// driven and popped when the DUT produces the corresponding event.
module tb_sys_cmd_parser;
   localparam int DW = 8, AW = 4, FW = 4, TMO = 16;
   localparam int K_NONE = 0, K_WR = 1, K_RD = 2, K_ALU = 3;

   logic            CLK = 1'b0;
   logic            RST;
   logic [DW-1:0]   RX_P_DATA;
   logic            RX_D_VLD, PAR_ERR, FRM_ERR;
   logic            WR_EN, RD_EN, ALU_EN;
   logic [AW-1:0]   ADDR;
   logic [DW-1:0]   WR_DATA, RD_DATA, OP_A, OP_B, TX_P_DATA;
   logic            RD_DATA_VLD, ALU_OUT_VLD, TX_D_VLD, TX_READY, BUSY, ERR;
   logic [FW-1:0]   ALU_FUN;
   logic [2*DW-1:0] ALU_OUT;
   logic [2:0]      ERR_CODE;

   always #5 CLK = ~CLK;

   sys_cmd_parser #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUN_WIDTH(FW), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .PAR_ERR(PAR_ERR), .FRM_ERR(FRM_ERR), .WR_EN(WR_EN), .RD_EN(RD_EN),
      .ADDR(ADDR), .WR_DATA(WR_DATA), .RD_DATA(RD_DATA), .RD_DATA_VLD(RD_DATA_VLD),
      .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .OP_A(OP_A), .OP_B(OP_B),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .TX_P_DATA(TX_P_DATA),
      .TX_D_VLD(TX_D_VLD), .TX_READY(TX_READY), .BUSY(BUSY), .ERR(ERR), .ERR_CODE(ERR_CODE));

   typedef struct {
      logic [31:0] w;      // frame words, first word in the top byte
      int          n;
      logic [1:0]  e;      // {frm, par} error on the last word
      int          kind;
      logic [3:0]  addr;
      logic [7:0]  wdata, opa, opb;
      logic [3:0]  fun;
      logic [15:0] rsp;
      int          err;    // expected error code, -1 for none
   } vec_t;

   vec_t       exp_iss[$];
   logic [7:0] exp_tx[$];
   logic [2:0] exp_err[$];
   int         n_chk = 0, n_fail = 0;
   bit         last_issue;
   vec_t       vt[14];

   function automatic vec_t mk(logic [31:0] w, int n, logic [1:0] e, int kind, logic [3:0] addr,
                               logic [7:0] wdata, logic [7:0] opa, logic [7:0] opb,
                               logic [3:0] fun, logic [15:0] rsp, int err);
      vec_t v;
      v.w = w; v.n = n; v.e = e; v.kind = kind; v.addr = addr; v.wdata = wdata;
      v.opa = opa; v.opb = opb; v.fun = fun; v.rsp = rsp; v.err = err;
      return v;
   endfunction

   function automatic logic [63:0] outs();
      return 64'({WR_EN, RD_EN, ADDR, WR_DATA, ALU_EN, ALU_FUN, OP_A, OP_B,
                  TX_P_DATA, TX_D_VLD, BUSY, ERR, ERR_CODE});
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One clock: score a TX transfer completing on this edge, advance, then
   // score request pulses and error pulses visible after the edge.
   task automatic tick();
      vec_t       e;
      logic [7:0] t;
      logic [2:0] c;
      if (TX_D_VLD && TX_READY) begin
         chk("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
         if (exp_tx.size() != 0) begin
            t = exp_tx.pop_front();
            chk("tx_data", 64'(TX_P_DATA), 64'(t));
         end
      end
      @(posedge CLK); #1;
      last_issue = WR_EN || RD_EN || ALU_EN;
      if (last_issue) begin
         chk("issue_expected", 64'(exp_iss.size() != 0), 64'd1);
         if (exp_iss.size() != 0) begin
            e = exp_iss.pop_front();
            chk("issue_kind", 64'(WR_EN ? K_WR : RD_EN ? K_RD : K_ALU), 64'(e.kind));
            if (e.kind == K_WR) begin
               chk("wr_addr", 64'(ADDR), 64'(e.addr));
               chk("wr_data", 64'(WR_DATA), 64'(e.wdata));
            end else if (e.kind == K_RD) begin
               chk("rd_addr", 64'(ADDR), 64'(e.addr));
            end else begin
               chk("alu_op_a", 64'(OP_A), 64'(e.opa));
               chk("alu_op_b", 64'(OP_B), 64'(e.opb));
               chk("alu_fun", 64'(ALU_FUN), 64'(e.fun));
            end
         end
      end
      if (ERR) begin
         chk("err_expected", 64'(exp_err.size() != 0), 64'd1);
         if (exp_err.size() != 0) begin
            c = exp_err.pop_front();
            chk("err_code", 64'(ERR_CODE), 64'(c));
         end
      end
   endtask

   task automatic send_word(input logic [7:0] w, input logic [1:0] e);
      RX_P_DATA = w; RX_D_VLD = 1'b1; PAR_ERR = e[0]; FRM_ERR = e[1];
      tick();
      RX_D_VLD = 1'b0; PAR_ERR = 1'b0; FRM_ERR = 1'b0;
   endtask

   task automatic wait_idle(input int lim);
      for (int i = 0; i < lim && BUSY; i++) tick();
      chk("busy_cleared", 64'(BUSY), 64'd0);
   endtask

   task automatic strobe_rsp(input int kind, input logic [15:0] rsp);
      if (kind == K_RD) begin RD_DATA = rsp[7:0]; RD_DATA_VLD = 1'b1; end
      else begin ALU_OUT = rsp; ALU_OUT_VLD = 1'b1; end
      tick();
      RD_DATA_VLD = 1'b0; ALU_OUT_VLD = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      if (v.kind != K_NONE) exp_iss.push_back(v);
      if (v.err >= 0) exp_err.push_back(3'(v.err));
      if (v.kind == K_RD) exp_tx.push_back(v.rsp[7:0]);
      if (v.kind == K_ALU) begin exp_tx.push_back(v.rsp[7:0]); exp_tx.push_back(v.rsp[15:8]); end
      for (int i = 0; i < v.n; i++) begin
         send_word(v.w[8*(3-i) +: 8], (i == v.n - 1) ? v.e : 2'b00);
         if (i < v.n - 1) tick();
      end
      chk("issue_latency", 64'(last_issue), 64'(v.kind != K_NONE));
      if (v.kind == K_RD || v.kind == K_ALU) begin
         tick(); tick();
         strobe_rsp(v.kind, v.rsp);
         chk("tx_vld_latency", 64'(TX_D_VLD), 64'd1);
      end
      wait_idle(20);
   endtask

   initial begin
      vec_t v;
      int   j;
      bit   hold;
      RST = 1'b1; RX_P_DATA = '0; RX_D_VLD = 1'b0; PAR_ERR = 1'b0; FRM_ERR = 1'b0;
      RD_DATA = '0; RD_DATA_VLD = 1'b0; ALU_OUT = '0; ALU_OUT_VLD = 1'b0; TX_READY = 1'b1;
      vt[0]  = mk(32'hAA053C00, 3, 2'b00, K_WR,  4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 16'h0000, -1);
      vt[1]  = mk(32'hBB050000, 2, 2'b00, K_RD,  4'h5, 8'h00, 8'h00, 8'h00, 4'h0, 16'h003C, -1);
      vt[2]  = mk(32'hCC0A0302, 4, 2'b00, K_ALU, 4'h0, 8'h00, 8'h0A, 8'h03, 4'h2, 16'h001E, -1);
      vt[3]  = mk(32'hDD000000, 2, 2'b00, K_ALU, 4'h0, 8'h00, 8'h0A, 8'h03, 4'h0, 16'h1234, -1);
      vt[4]  = mk(32'h55000000, 1, 2'b00, K_NONE, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 16'h0000, 1);
      vt[5]  = mk(32'hAA050000, 2, 2'b01, K_NONE, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 16'h0000, 3);
      vt[6]  = mk(32'hAA0FFF00, 3, 2'b00, K_WR,  4'hF, 8'hFF, 8'h00, 8'h00, 4'h0, 16'h0000, -1);
      vt[7]  = mk(32'hBB1F0000, 2, 2'b00, K_RD,  4'hF, 8'h00, 8'h00, 8'h00, 4'h0, 16'h00A5, -1);
      vt[8]  = mk(32'hCCFFFF0F, 4, 2'b00, K_ALU, 4'h0, 8'h00, 8'hFF, 8'hFF, 4'hF, 16'hFE01, -1);
      vt[9]  = mk(32'hDD170000, 2, 2'b00, K_ALU, 4'h0, 8'h00, 8'hFF, 8'hFF, 4'h7, 16'h0000, -1);
      vt[10] = mk(32'hBB000000, 1, 2'b10, K_NONE, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 16'h0000, 3);
      vt[11] = mk(32'h00000000, 1, 2'b00, K_NONE, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 16'h0000, 1);
      vt[12] = mk(32'hCC010000, 2, 2'b01, K_NONE, 4'h0, 8'h00, 8'h00, 8'h00, 4'h0, 16'h0000, 3);
      vt[13] = mk(32'hDD030000, 2, 2'b00, K_ALU, 4'h0, 8'h00, 8'hFF, 8'hFF, 4'h3, 16'h00FF, -1);

      tick(); tick(); tick();
      RST = 1'b0;
      chk("reset_outputs", outs(), 64'd0);

      foreach (vt[i]) run_vec(vt[i]);

      // read with TX back-pressure: word must hold for 10 cycles
      TX_READY = 1'b0;
      v = mk(32'hBB050000, 2, 2'b00, K_RD, 4'h5, 8'h00, 8'h00, 8'h00, 4'h0, 16'h003C, -1);
      exp_iss.push_back(v); exp_tx.push_back(8'h3C);
      send_word(8'hBB, 2'b00); tick(); send_word(8'h05, 2'b00);
      tick(); tick();
      strobe_rsp(K_RD, 16'h003C);
      hold = 1'b1;
      for (int i = 0; i < 10; i++) begin
         hold &= (TX_D_VLD === 1'b1) && (TX_P_DATA === 8'h3C);
         tick();
      end
      chk("tx_hold", 64'(hold), 64'd1);
      TX_READY = 1'b1;
      wait_idle(10);

      // inter-word timeout: error exactly TMO cycles after the accepting edge
      exp_err.push_back(3'd2);
      send_word(8'hAA, 2'b00);
      j = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (ERR) begin j = i; break; end
      end
      chk("get_timeout_cycles", 64'(j), 64'(TMO));
      wait_idle(5);

      // line error on the same edge as the timeout reports code 3
      exp_err.push_back(3'd3);
      send_word(8'hAA, 2'b00);
      for (int i = 0; i < TMO - 1; i++) tick();
      send_word(8'h05, 2'b01);
      chk("rx_err_beats_timeout", 64'(ERR_CODE), 64'd3);
      wait_idle(5);

      // read never answered: response timeout
      v = mk(32'hBB050000, 2, 2'b00, K_RD, 4'h5, 8'h00, 8'h00, 8'h00, 4'h0, 16'h0000, 5);
      exp_iss.push_back(v); exp_err.push_back(3'd5);
      send_word(8'hBB, 2'b00); tick(); send_word(8'h05, 2'b00);
      wait_idle(40);
      tick(); tick();
      chk("err_code_hold", 64'(ERR_CODE), 64'd5);

      // response on the same edge as the response timeout is taken
      v = mk(32'hBB060000, 2, 2'b00, K_RD, 4'h6, 8'h00, 8'h00, 8'h00, 4'h0, 16'h005A, -1);
      exp_iss.push_back(v); exp_tx.push_back(8'h5A);
      send_word(8'hBB, 2'b00); tick(); send_word(8'h06, 2'b00);
      for (int i = 0; i < TMO; i++) tick();
      strobe_rsp(K_RD, 16'h005A);
      chk("rsp_beats_timeout", 64'(TX_D_VLD), 64'd1);
      wait_idle(10);

      // word arriving in WAIT_RSP is dropped with code 4, read completes
      v = mk(32'hBB070000, 2, 2'b00, K_RD, 4'h7, 8'h00, 8'h00, 8'h00, 4'h0, 16'h0077, 4);
      exp_iss.push_back(v); exp_err.push_back(3'd4); exp_tx.push_back(8'h77);
      send_word(8'hBB, 2'b00); tick(); send_word(8'h07, 2'b00);
      tick();
      send_word(8'h99, 2'b00);
      strobe_rsp(K_RD, 16'h0077);
      wait_idle(10);

      // reset in GET_OPB clears everything; next CC frame parses normally
      send_word(8'hCC, 2'b00); tick(); send_word(8'h11, 2'b00);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("midframe_reset_outputs", outs(), 64'd0);
      run_vec(vt[2]);

      chk("iss_queue_empty", 64'(exp_iss.size()), 64'd0);
      chk("tx_queue_empty", 64'(exp_tx.size()), 64'd0);
      chk("err_queue_empty", 64'(exp_err.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
